// File: rtl/simon_pkg.sv
// Shared definitions for the Simon sequence player: colour codes,
// colour-to-LED mapping, FSM state encoding and the default sequence length.
package simon_pkg;

    localparam int MAX_LEN = 16;

    localparam logic [1:0] COL_GREEN  = 2'b00;
    localparam logic [1:0] COL_RED    = 2'b01;
    localparam logic [1:0] COL_YELLOW = 2'b10;
    localparam logic [1:0] COL_BLUE   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // 2-bit colour code to one-hot LED drive
    function automatic logic [3:0] colour_onehot(input logic [1:0] c);
        logic [3:0] oh;
        oh = 4'b0000;
        case (c)
            COL_GREEN:  oh = 4'b0001;
            COL_RED:    oh = 4'b0010;
            COL_YELLOW: oh = 4'b0100;
            COL_BLUE:   oh = 4'b1000;
            default:    oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// The pulse appears 3 clk after the asynchronous input rises.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    // Synchronize, remember previous level, register the edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= in;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/simon_sequence_player.sv
// Plays a latched sequence of colours on a one-hot LED output, timing each
// lit/dark phase in ticks derived from a slow clock sampled as data.
module simon_sequence_player
    import simon_pkg::*;
#(
    parameter int ON_TICKS  = 3,
    parameter int OFF_TICKS = 1,
    parameter int MAX_LEN   = simon_pkg::MAX_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        slow_clk,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  seq_len,
    input  logic [31:0] seq_data,
    output logic [3:0]  led,
    output logic        busy,
    output logic        done,
    output logic [3:0]  step
);

    localparam int CNT_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
    localparam logic [4:0]       LEN_CAP  = 5'(MAX_LEN);

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_step,  w_step_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [31:0]      r_data,  w_data_nxt;
    logic [4:0]       r_len,   w_len_nxt;
    logic [3:0]       r_led,   w_led_nxt;
    logic             r_done,  w_done_nxt;

    logic             w_tick;
    logic [4:0]       w_len_eff;
    logic [3:0]       w_step_inc;
    logic [1:0]       w_col_inc;
    logic             w_last;

    edge_sync u_tick (
        .clk   (clk),
        .rst   (rst),
        .in    (slow_clk),
        .pulse (w_tick)
    );

    assign w_len_eff  = (seq_len > LEN_CAP) ? LEN_CAP : seq_len;
    assign w_step_inc = r_step + 4'd1;
    assign w_col_inc  = 2'(r_data >> {w_step_inc, 1'b0});
    assign w_last     = ({1'b0, r_step} == (r_len - 5'd1));

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_len   <= '0;
            r_led   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_len   <= w_len_nxt;
            r_led   <= w_led_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; LED value is computed one step ahead so it is registered
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_len_nxt   = r_len;
        w_led_nxt   = r_led;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_led_nxt = 4'b0000;
                // ticks arriving while idle (including the start cycle) are dropped
                if (start) begin
                    w_data_nxt = seq_data;
                    w_len_nxt  = w_len_eff;
                    w_step_nxt = '0;
                    w_cnt_nxt  = '0;
                    if (w_len_eff == 5'd0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ON;
                        w_led_nxt   = colour_onehot(seq_data[1:0]);
                    end
                end
            end
            ST_ON: begin
                if (w_tick) begin
                    if (r_cnt == ON_LAST) begin
                        w_state_nxt = ST_OFF;
                        w_cnt_nxt   = '0;
                        w_led_nxt   = 4'b0000;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_OFF: begin
                if (w_tick) begin
                    if (r_cnt == OFF_LAST) begin
                        w_cnt_nxt = '0;
                        if (w_last) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_step_nxt  = w_step_inc;
                            w_state_nxt = ST_ON;
                            w_led_nxt   = colour_onehot(w_col_inc);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_led_nxt   = 4'b0000;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_led_nxt   = 4'b0000;
            end
        endcase

        // abort wins over everything, including a same-cycle start
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_led_nxt   = 4'b0000;
            w_done_nxt  = 1'b0;
        end
    end

    assign led  = r_led;
    assign busy = (r_state == ST_ON) || (r_state == ST_OFF);
    assign done = r_done;
    assign step = r_step;

endmodule

// File: tb/tb_simon_sequence_player.sv
// Directed bench for simon_sequence_player with hand-computed expectations.
module tb_simon_sequence_player;

    localparam int ON_T  = 2;
    localparam int OFF_T = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slow_clk = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  seq_len = '0;
    logic [31:0] seq_data = '0;
    logic [3:0]  led;
    logic        busy;
    logic        done;
    logic [3:0]  step;

    bit          slow_en = 1'b0;
    int          nvec = 0;
    int          nbad = 0;
    int          n_done = 0;
    bit          busy_seen = 1'b0;

    logic [3:0]  sv[$];
    int          sl[$];
    logic [3:0]  e1[6] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0};

    simon_sequence_player #(.ON_TICKS(ON_T), .OFF_TICKS(OFF_T)) dut (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_clk),
        .start    (start),
        .abort    (abort),
        .seq_len  (seq_len),
        .seq_data (seq_data),
        .led      (led),
        .busy     (busy),
        .done     (done),
        .step     (step)
    );

    always #5 clk = ~clk;
    // slow clock: 8 clk period, edges land between clk edges
    always #40 if (slow_en) slow_clk = ~slow_clk;

    always @(negedge clk) begin
        if (done) n_done++;
        if (busy) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // record runs of constant led value until done or budget expires
    task automatic capture(input int budget, output bit got_done);
        logic [3:0] cur;
        int len;
        sv.delete();
        sl.delete();
        got_done = 1'b0;
        cur = led;
        len = 1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (led == cur) len++;
            else begin
                sv.push_back(cur);
                sl.push_back(len);
                cur = led;
                len = 1;
            end
        end
        sv.push_back(cur);
        sl.push_back(len);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit gd;
        bit found;
        int nz;
        logic [3:0] lastnz;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_step", step, 0);
        @(negedge clk) rst = 1'b0;
        slow_en = 1'b1;

        // basic 3-step playback
        seq_data = 32'h24; seq_len = 5'd3; d0 = n_done;
        pulse_start();
        capture(600, gd);
        chk("t1_done", gd, 1);
        chk("t1_nseg", sv.size(), 6);
        if (sv.size() == 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("t1_led%0d", i), sv[i], e1[i]);
            chk("t1_off0_len", sl[1], 8);
            chk("t1_on1_len", sl[2], 16);
            chk("t1_off1_len", sl[3], 8);
            chk("t1_on2_len", sl[4], 16);
        end
        repeat (5) @(negedge clk);
        chk("t1_ndone", n_done - d0, 1);
        chk("t1_busy", busy, 0);
        chk("t1_step", step, 2);

        // zero length
        seq_len = 5'd0; d0 = n_done;
        @(negedge clk) start = 1'b1; busy_seen = 1'b0;
        @(negedge clk) start = 1'b0;
        chk("t2_done_early", done, 0);
        @(negedge clk);
        chk("t2_done", done, 1);
        chk("t2_led", led, 0);
        repeat (4) @(negedge clk);
        chk("t2_busy_seen", busy_seen, 0);
        chk("t2_ndone", n_done - d0, 1);

        // length clamp at 16
        seq_data = 32'hE4E4_E4E4; seq_len = 5'd20; d0 = n_done;
        pulse_start();
        capture(1500, gd);
        nz = 0; lastnz = 4'h0;
        foreach (sv[i]) if (sv[i] != 4'h0) begin nz++; lastnz = sv[i]; end
        chk("t3_done", gd, 1);
        chk("t3_nsteps", nz, 16);
        chk("t3_last_led", lastnz, 4'b1000);
        repeat (5) @(negedge clk);
        chk("t3_step", step, 15);
        chk("t3_ndone", n_done - d0, 1);

        // abort during step 1 ON
        seq_data = 32'h24; seq_len = 5'd3; d0 = n_done;
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (step == 4'd1 && led != 4'h0) begin found = 1'b1; break; end
        end
        chk("t4_reach_step1", found, 1);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("t4_led", led, 0);
        chk("t4_busy", busy, 0);
        repeat (40) @(negedge clk);
        chk("t4_no_done", n_done - d0, 0);
        chk("t4_idle", busy, 0);
        pulse_start();
        chk("t4_replay_led", led, 4'b0001);
        chk("t4_replay_step", step, 0);
        chk("t4_replay_busy", busy, 1);
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;

        // restart attempt and data change mid-run are ignored
        seq_data = 32'h24; seq_len = 5'd3; d0 = n_done;
        pulse_start();
        fork
            capture(600, gd);
            begin
                repeat (20) @(negedge clk);
                start = 1'b1; seq_data = 32'hFFFF_FFFF; seq_len = 5'd1;
                @(negedge clk) start = 1'b0;
            end
        join
        chk("t5_done", gd, 1);
        chk("t5_nseg", sv.size(), 6);
        if (sv.size() == 6)
            for (int i = 0; i < 6; i++) chk($sformatf("t5_led%0d", i), sv[i], e1[i]);
        repeat (5) @(negedge clk);
        chk("t5_ndone", n_done - d0, 1);

        // async reset mid-OFF
        seq_data = 32'h24; seq_len = 5'd3; d0 = n_done;
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy && led == 4'h0) begin found = 1'b1; break; end
        end
        chk("t6_reach_off", found, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_led", led, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_step", step, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        slow_en = 1'b0;
        slow_clk = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6_no_done", n_done - d0, 0);
        chk("t6_idle", busy, 0);

        // tick coinciding with the start cycle is not counted
        seq_data = 32'h24; seq_len = 5'd3;
        @(negedge clk) slow_clk = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_on_busy", busy, 1);
        chk("t6_on_led", led, 4'b0001);
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        slow_clk = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_one_tick_led", led, 4'b0001);
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        slow_clk = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_two_tick_led", led, 4'b0000);
        chk("t6_two_tick_busy", busy, 1);
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
